// File: rtl/axis_cpu_progmem_pkg.sv
// Shared command-stream encodings, response kinds and status word layout for axis_cpu_progmem.
package axis_cpu_progmem_pkg;

  localparam int unsigned CMD_WIDTH = 32;
  localparam int unsigned OP_MSB    = 31;
  localparam int unsigned OP_LSB    = 28;
  localparam int unsigned PAY_WIDTH = 28;

  localparam logic [3:0] OP_NOP       = 4'h0;
  localparam logic [3:0] OP_SET_ADDR  = 4'h1;
  localparam logic [3:0] OP_WR_INST   = 4'h2;
  localparam logic [3:0] OP_WR_IMM_LO = 4'h3;
  localparam logic [3:0] OP_WR_IMM_HI = 4'h4;
  localparam logic [3:0] OP_RUN       = 4'h5;
  localparam logic [3:0] OP_HALT      = 4'h6;
  localparam logic [3:0] OP_STEP      = 4'h7;
  localparam logic [3:0] OP_RD_INST   = 4'h8;
  localparam logic [3:0] OP_RD_IMM    = 4'h9;
  localparam logic [3:0] OP_STATUS    = 4'hA;
  localparam logic [3:0] OP_CLR_ERR   = 4'hB;
  localparam logic [3:0] OP_TRACE     = 4'hE;

  typedef enum logic [1:0] {
    RSP_NONE,
    RSP_INST,
    RSP_IMM,
    RSP_STAT
  } rsp_kind_e;

  // Status word: bit31 hold, bit30 step_mode, bit29 err, [15:0] step count
  typedef struct packed {
    logic        hold;
    logic        step_mode;
    logic        err;
    logic [12:0] rsvd;
    logic [15:0] step_cnt;
  } status_t;

endpackage

// File: rtl/axis_cpu_progmem_sdp_ram.sv
// Simple dual-port RAM: one write port, one registered read port with read enable.
module axis_cpu_progmem_sdp_ram #(
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  re,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  localparam int unsigned DEPTH = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/axis_cpu_progmem.sv
// Program store and run control for one axis_cpu core.
// Optional AXIS_CPU_PROGMEM_TRACE_EN adds step-mode fetch trace words on cmd_out.
module axis_cpu_progmem
  import axis_cpu_progmem_pkg::*;
#(
  parameter int unsigned CODE_ADDR_WIDTH = 10,
  parameter int unsigned CODE_DATA_WIDTH = 8,
  parameter int unsigned IMM_ADDR_WIDTH  = 8,
  parameter int unsigned IMM_WIDTH       = 32,
  parameter int unsigned STEP_WIDTH      = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [CMD_WIDTH-1:0]       cmd_in_TDATA,
  input  logic                       cmd_in_TVALID,
  output logic [CMD_WIDTH-1:0]       cmd_out_TDATA,
  output logic                       cmd_out_TVALID,
  input  logic [CODE_ADDR_WIDTH-1:0] core_inst_rd_addr,
  input  logic                       core_inst_rd_en,
  output logic [CODE_DATA_WIDTH-1:0] inst_out,
  output logic                       inst_vld,
  input  logic [IMM_ADDR_WIDTH-1:0]  core_imm_rd_addr,
  output logic [IMM_WIDTH-1:0]       imm_out,
  output logic                       cpu_hold
);

  logic [3:0]                 op_c;
  logic [PAY_WIDTH-1:0]       pay_c;
  logic                       cmd_c, mem_op_c, mem_ok_c, mem_bad_c, halt_c, grant_c;
  logic                       step_mode, err;
  logic [STEP_WIDTH-1:0]      step_cnt;
  logic [CODE_ADDR_WIDTH-1:0] addr;
  logic [15:0]                imm_lo;
  logic                       inst_re_c;
  logic [CODE_ADDR_WIDTH-1:0] inst_raddr_c;
  logic [IMM_ADDR_WIDTH-1:0]  imm_raddr_c;
  logic [CODE_DATA_WIDTH-1:0] inst_rdata, inst_last;
  rsp_kind_e                  rsp_kind, rsp_next_c;
  status_t                    status_c, stat_q;
  logic                       rsp_vld_c;
  logic [CMD_WIDTH-1:0]       rsp_data_c;
  logic                       unused_pay_bits;
`ifdef AXIS_CPU_PROGMEM_TRACE_EN
  logic                       trace_vld;
  logic [CMD_WIDTH-1:0]       trace_word;
  logic                       buf_vld;
  status_t                    buf_q;
`endif

  assign op_c            = cmd_in_TDATA[OP_MSB:OP_LSB];
  assign pay_c           = cmd_in_TDATA[PAY_WIDTH-1:0];
  assign unused_pay_bits = ^pay_c;

  assign cmd_c     = cmd_in_TVALID & ~rst;
  assign mem_op_c  = cmd_c & ((op_c == OP_WR_INST) | (op_c == OP_WR_IMM_HI) |
                              (op_c == OP_RD_INST) | (op_c == OP_RD_IMM));
  assign mem_ok_c  = mem_op_c & cpu_hold;
  assign mem_bad_c = mem_op_c & ~cpu_hold;
  assign halt_c    = cmd_c & (op_c == OP_HALT);
  assign grant_c   = core_inst_rd_en & ~cpu_hold & (~step_mode | (step_cnt != '0)) & ~halt_c;

  // Read ports follow the core while running and the command address while held
  assign inst_re_c    = grant_c | (mem_ok_c & (op_c == OP_RD_INST));
  assign inst_raddr_c = cpu_hold ? addr : core_inst_rd_addr;
  assign imm_raddr_c  = cpu_hold ? addr[IMM_ADDR_WIDTH-1:0] : core_imm_rd_addr;

  axis_cpu_progmem_sdp_ram #(
    .ADDR_WIDTH(CODE_ADDR_WIDTH),
    .DATA_WIDTH(CODE_DATA_WIDTH)
  ) u_inst_mem (
    .clk  (clk),
    .we   (mem_ok_c & (op_c == OP_WR_INST)),
    .waddr(addr),
    .wdata(pay_c[CODE_DATA_WIDTH-1:0]),
    .re   (inst_re_c),
    .raddr(inst_raddr_c),
    .rdata(inst_rdata)
  );

  axis_cpu_progmem_sdp_ram #(
    .ADDR_WIDTH(IMM_ADDR_WIDTH),
    .DATA_WIDTH(IMM_WIDTH)
  ) u_imm_mem (
    .clk  (clk),
    .we   (mem_ok_c & (op_c == OP_WR_IMM_HI)),
    .waddr(addr[IMM_ADDR_WIDTH-1:0]),
    .wdata({pay_c[IMM_WIDTH-17:0], imm_lo}),
    .re   (1'b1),
    .raddr(imm_raddr_c),
    .rdata(imm_out)
  );

  // Command reads share the RAM output, so the core sees the last granted word
  always_ff @(posedge clk) begin
    if (inst_vld) inst_last <= inst_rdata;
  end
  assign inst_out = inst_vld ? inst_rdata : inst_last;

  always_comb begin
    status_c           = '0;
    status_c.hold      = cpu_hold;
    status_c.step_mode = step_mode;
    status_c.err       = err;
    status_c.step_cnt  = 16'(step_cnt);
    rsp_next_c         = RSP_NONE;
    if (mem_ok_c && op_c == OP_RD_INST)     rsp_next_c = RSP_INST;
    else if (mem_ok_c && op_c == OP_RD_IMM) rsp_next_c = RSP_IMM;
    else if (cmd_c && op_c == OP_STATUS)    rsp_next_c = RSP_STAT;
    rsp_vld_c  = 1'b1;
    rsp_data_c = stat_q;
    case (rsp_kind)
      RSP_INST: rsp_data_c = 32'(inst_rdata);
      RSP_IMM:  rsp_data_c = 32'(imm_out);
      RSP_STAT: rsp_data_c = stat_q;
      default:  rsp_vld_c  = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cpu_hold       <= 1'b1;
      step_mode      <= 1'b0;
      step_cnt       <= '0;
      addr           <= '0;
      imm_lo         <= '0;
      err            <= 1'b0;
      inst_vld       <= 1'b0;
      rsp_kind       <= RSP_NONE;
      stat_q         <= '0;
      cmd_out_TVALID <= 1'b0;
      cmd_out_TDATA  <= '0;
`ifdef AXIS_CPU_PROGMEM_TRACE_EN
      trace_vld      <= 1'b0;
      trace_word     <= '0;
      buf_vld        <= 1'b0;
      buf_q          <= '0;
`endif
    end else begin
      inst_vld <= grant_c;
      rsp_kind <= rsp_next_c;
      stat_q   <= status_c;
      if (grant_c && step_mode) step_cnt <= step_cnt - STEP_WIDTH'(1);
      if (mem_bad_c) err <= 1'b1;
      if (mem_ok_c) addr <= addr + CODE_ADDR_WIDTH'(1);
      if (cmd_c) begin
        // Later assignments here override the fetch decrement above
        case (op_c)
          OP_SET_ADDR:  addr   <= pay_c[CODE_ADDR_WIDTH-1:0];
          OP_WR_IMM_LO: imm_lo <= pay_c[15:0];
          OP_RUN: begin
            cpu_hold  <= 1'b0;
            step_mode <= 1'b0;
          end
          OP_HALT: begin
            cpu_hold  <= 1'b1;
            step_mode <= 1'b0;
            step_cnt  <= '0;
          end
          OP_STEP: begin
            cpu_hold  <= 1'b0;
            step_mode <= 1'b1;
            step_cnt  <= pay_c[STEP_WIDTH-1:0];
          end
          OP_CLR_ERR:   err <= 1'b0;
          default: ;
        endcase
      end
`ifdef AXIS_CPU_PROGMEM_TRACE_EN
      trace_vld  <= grant_c & step_mode;
      trace_word <= {OP_TRACE, 28'(core_inst_rd_addr)};
      // Trace owns the slot; a colliding STATUS parks in the single buffer
      if (trace_vld) begin
        cmd_out_TVALID <= 1'b1;
        cmd_out_TDATA  <= trace_word;
        if (rsp_kind == RSP_STAT) begin
          if (buf_vld) begin
            err <= 1'b1;
          end else begin
            buf_vld <= 1'b1;
            buf_q   <= stat_q;
          end
        end
      end else if (rsp_vld_c) begin
        cmd_out_TVALID <= 1'b1;
        cmd_out_TDATA  <= rsp_data_c;
      end else if (buf_vld) begin
        cmd_out_TVALID <= 1'b1;
        cmd_out_TDATA  <= buf_q;
        buf_vld        <= 1'b0;
      end else begin
        cmd_out_TVALID <= 1'b0;
      end
`else
      cmd_out_TVALID <= rsp_vld_c;
      if (rsp_vld_c) cmd_out_TDATA <= rsp_data_c;
`endif
    end
  end

endmodule
